os_array_ctrl: RTL

Sequencer for the output-stationary systolic array built from `processing_element_os` tiles. It takes one GEMM tile command (reduction length K) and runs it to completion:
- clears the array;
- streams K skewed operand beats and flushes the wavefront through the multiplier pipeline;
- captures the accumulators into the scan chain and drains them row by row to the output buffer under a valid/ready handshake.

It sits between the tile-level command interface and the array's shared control nets (`reg_clear`, `pipeline_en`, `cell_en`, `cscan_en`).

---
 rtl/sa_ctrl_pkg.sv | 53 +++++
 rtl/os_array_ctrl_if.sv | 36 +++
 rtl/sa_ctrl_counter.sv | 29 ++
 rtl/os_array_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array sequencers: state encoding,
// flush/counter sizing helpers and control-bundle bit positions.
package sa_ctrl_pkg;

  localparam logic [2:0] SA_ST_IDLE    = 3'd0;
  localparam logic [2:0] SA_ST_CLEAR   = 3'd1;
  localparam logic [2:0] SA_ST_FEED    = 3'd2;
  localparam logic [2:0] SA_ST_FLUSH   = 3'd3;
  localparam logic [2:0] SA_ST_CAPTURE = 3'd4;
  localparam logic [2:0] SA_ST_DRAIN   = 3'd5;
  localparam logic [2:0] SA_ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = SA_ST_IDLE,
    ST_CLEAR   = SA_ST_CLEAR,
    ST_FEED    = SA_ST_FEED,
    ST_FLUSH   = SA_ST_FLUSH,
    ST_CAPTURE = SA_ST_CAPTURE,
    ST_DRAIN   = SA_ST_DRAIN,
    ST_DONE    = SA_ST_DONE
  } sa_state_t;

  // Bit positions inside the registered array-control bundle.
  localparam int unsigned CB_REG_CLEAR   = 0;
  localparam int unsigned CB_PIPELINE_EN = 1;
  localparam int unsigned CB_CELL_EN     = 2;
  localparam int unsigned CB_OP_RD_EN    = 3;
  localparam int unsigned CB_OP_ZERO     = 4;
  localparam int unsigned CB_OUT_VALID   = 5;
  localparam int unsigned CB_W           = 6;

  // Bits needed to index v values; never less than 1.
  function automatic int unsigned sa_clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Cycles of zero operands needed to push the skewed wavefront through.
  function automatic int unsigned sa_flush_len(input int unsigned rows,
                                               input int unsigned cols,
                                               input int unsigned stage);
    return rows + cols - 1 + stage;
  endfunction

  function automatic int unsigned sa_flush_w(input int unsigned rows,
                                             input int unsigned cols,
                                             input int unsigned stage);
    return sa_clog2(sa_flush_len(rows, cols, stage) + 1);
  endfunction

endpackage

// File: rtl/os_array_ctrl_if.sv
// Command, array-control and drain-handshake nets of the array sequencer.
interface os_array_ctrl_if #(
  parameter int unsigned K_W   = 12,
  parameter int unsigned ROW_W = 2
);
  logic             start;
  logic [K_W-1:0]   k_len;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic             reg_clear;
  logic             pipeline_en;
  logic             cell_en;
  logic             cscan_en;
  logic             op_rd_en;
  logic             op_zero;
  logic [K_W-1:0]   rd_idx;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;

  // Command issuer / output buffer side.
  modport master (
    output start, k_len, abort, out_ready,
    input  busy, done, err, reg_clear, pipeline_en, cell_en, cscan_en,
           op_rd_en, op_zero, rd_idx, out_valid, out_row
  );

  // Sequencer side.
  modport slave (
    input  start, k_len, abort, out_ready,
    output busy, done, err, reg_clear, pipeline_en, cell_en, cscan_en,
           op_rd_en, op_zero, rd_idx, out_valid, out_row
  );
endinterface

// File: rtl/sa_ctrl_counter.sv
// Loadable down-counter that stops at zero and flags it.
module sa_ctrl_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_term_c
);
  logic [W-1:0] r_cnt;

  // Clear beats load, load beats decrement; holds at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_term_c = (r_cnt == '0);
endmodule

// File: rtl/os_array_ctrl.sv
// Tile sequencer for the output-stationary systolic array: clear, feed K
// operand beats, flush the wavefront, capture, then drain rows by handshake.
module os_array_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned STAGE = 0,
  parameter int unsigned K_W   = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  os_array_ctrl_if.slave bus
);
  localparam int unsigned F       = sa_flush_len(ROWS, COLS, STAGE);
  localparam int unsigned FLUSH_W = sa_flush_w(ROWS, COLS, STAGE);
  localparam int unsigned ROW_W   = sa_clog2(ROWS);

  sa_state_t        r_state;
  sa_state_t        w_state_nxt;
  logic [CB_W-1:0]  r_ctrl;
  logic [CB_W-1:0]  w_ctrl_nxt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [K_W-1:0]   r_rd_idx;
  logic [K_W-1:0]   w_rd_idx_nxt;
  logic [ROW_W-1:0] r_out_row;
  logic [ROW_W-1:0] w_out_row_nxt;

  logic w_accept;
  logic w_abort;
  logic w_hs;
  logic w_k_zero;
  logic w_k_term;
  logic w_flush_term;
  logic w_row_term;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_abort  = bus.abort && (r_state != ST_IDLE);
  assign w_hs     = (r_state == ST_DRAIN) && bus.out_ready;
  assign w_k_zero = (bus.k_len == '0);

  // Remaining operand beats; terminal on the last FEED beat.
  sa_ctrl_counter #(.W(K_W)) u_k_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_abort),
    .i_load     (w_accept && !w_k_zero),
    .i_load_val (K_W'(bus.k_len - K_W'(1))),
    .i_dec      (r_state == ST_FEED),
    .o_term_c   (w_k_term)
  );

  // Remaining flush beats; loaded on the last FEED beat.
  sa_ctrl_counter #(.W(FLUSH_W)) u_flush_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_abort),
    .i_load     ((r_state == ST_FEED) && w_k_term),
    .i_load_val (FLUSH_W'(F - 1)),
    .i_dec      (r_state == ST_FLUSH),
    .o_term_c   (w_flush_term)
  );

  // Remaining rows to drain; only a handshake consumes one.
  sa_ctrl_counter #(.W(ROW_W)) u_row_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_abort),
    .i_load     (r_state == ST_CAPTURE),
    .i_load_val (ROW_W'(ROWS - 1)),
    .i_dec      (w_hs),
    .o_term_c   (w_row_term)
  );

  // Next-state selection; abort overrides everything outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (bus.start) w_state_nxt = w_k_zero ? ST_DONE : ST_CLEAR;
      ST_CLEAR:   w_state_nxt = ST_FEED;
      ST_FEED:    if (w_k_term) w_state_nxt = ST_FLUSH;
      ST_FLUSH:   if (w_flush_term) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_hs && w_row_term) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = ST_DONE;
  end

  // Control bundle, operand index and drain row for the upcoming cycle.
  always_comb begin
    w_ctrl_nxt    = '0;
    w_rd_idx_nxt  = '0;
    w_out_row_nxt = '0;
    case (w_state_nxt)
      ST_CLEAR: w_ctrl_nxt[CB_REG_CLEAR] = 1'b1;
      ST_FEED: begin
        w_ctrl_nxt[CB_PIPELINE_EN] = 1'b1;
        w_ctrl_nxt[CB_CELL_EN]     = 1'b1;
        w_ctrl_nxt[CB_OP_RD_EN]    = 1'b1;
      end
      ST_FLUSH: begin
        w_ctrl_nxt[CB_PIPELINE_EN] = 1'b1;
        w_ctrl_nxt[CB_CELL_EN]     = 1'b1;
        w_ctrl_nxt[CB_OP_ZERO]     = 1'b1;
      end
      ST_CAPTURE: begin
        w_ctrl_nxt[CB_PIPELINE_EN] = 1'b1;
        w_ctrl_nxt[CB_CELL_EN]     = 1'b1;
      end
      ST_DRAIN: w_ctrl_nxt[CB_OUT_VALID] = 1'b1;
      default: ;
    endcase
    // An aborted tile leaves the array cleared in its DONE cycle.
    if (w_abort) w_ctrl_nxt[CB_REG_CLEAR] = 1'b1;
    if ((w_state_nxt == ST_FEED) && (r_state == ST_FEED)) begin
      w_rd_idx_nxt = r_rd_idx + K_W'(1);
    end
    if ((w_state_nxt == ST_DRAIN) && (r_state == ST_DRAIN)) begin
      w_out_row_nxt = r_out_row;
      if (w_hs && (r_out_row != ROW_W'(ROWS - 1))) begin
        w_out_row_nxt = r_out_row + ROW_W'(1);
      end
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_idx  <= '0;
      r_out_row <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
      r_err     <= w_accept && w_k_zero;
      r_rd_idx  <= w_rd_idx_nxt;
      r_out_row <= w_out_row_nxt;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.reg_clear   = r_ctrl[CB_REG_CLEAR];
  assign bus.pipeline_en = r_ctrl[CB_PIPELINE_EN];
  assign bus.cell_en     = r_ctrl[CB_CELL_EN];
  assign bus.op_rd_en    = r_ctrl[CB_OP_RD_EN];
  assign bus.op_zero     = r_ctrl[CB_OP_ZERO];
  assign bus.out_valid   = r_ctrl[CB_OUT_VALID];
  assign bus.rd_idx      = r_rd_idx;
  assign bus.out_row     = r_out_row;
  // Scan shift follows the output buffer's ready directly while draining.
  assign bus.cscan_en    = w_hs;
endmodule
